// File: rtl/spi_adc_responder.sv
`timescale 1ns/1ps
// spi_adc_responder: 32-bit SPI mode-1 responder with holding register; define SPI_ADC_RESPONDER_CMD_ECHO_EN to echo the last command's upper half on underrun
module spi_adc_responder #(
    parameter int FRAME_BITS = 32
) (
    input  logic        system_clock,
    input  logic        reset,
    input  logic        SPI_SCLK,
    input  logic        SPI_CS,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        frame_error,
    output logic        tx_underrun,
    output logic [5:0]  bit_count_output
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    localparam logic [1:0] ABORT  = 2'd3;
    localparam logic [5:0] FRAME_LEN = 6'(FRAME_BITS);
    logic [2:0]  sclk_q;
    logic [2:0]  cs_q;
    logic [1:0]  mosi_q;
    logic [1:0]  state;
    logic        hold_full;
    logic [31:0] hold_data;
    logic [31:0] tx_shift;
    logic [31:0] rx_shift;
    logic [31:0] default_word;
    logic        accept;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        cs_fall;
    logic        cs_rise;
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign tx_ready  = ~hold_full;
    assign accept    = tx_valid & ~hold_full;
`ifdef SPI_ADC_RESPONDER_CMD_ECHO_EN
    assign default_word = {rx_data[31:16], 16'h0000};
`else
    assign default_word = 32'h0000_0000;
`endif
    // Synchronizers keep sampling through reset so the post-reset state sees the true CS level
    always_ff @(posedge system_clock) begin
        sclk_q <= {sclk_q[1:0], SPI_SCLK};
        cs_q   <= {cs_q[1:0], SPI_CS};
        mosi_q <= {mosi_q[0], SPI_MOSI};
    end
    // Frame FSM, holding register, shift registers and status strobes
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state            <= cs_q[1] ? IDLE : ABORT;
            hold_full        <= 1'b0;
            hold_data        <= '0;
            tx_shift         <= '0;
            rx_shift         <= '0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            frame_error      <= 1'b0;
            tx_underrun      <= 1'b0;
            bit_count_output <= '0;
            SPI_MISO         <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            tx_underrun <= 1'b0;
            if (accept) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end
            case (state)
                IDLE: begin
                    SPI_MISO <= 1'b0;
                    if (cs_fall) begin
                        state            <= ACTIVE;
                        bit_count_output <= '0;
                        rx_shift         <= '0;
                        hold_full        <= 1'b0;
                        tx_shift         <= accept ? tx_data : hold_full ? hold_data : default_word;
                        tx_underrun      <= ~accept & ~hold_full;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state    <= FINISH;
                        SPI_MISO <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            SPI_MISO <= tx_shift[31];
                            tx_shift <= {tx_shift[30:0], 1'b0};
                        end
                        if (sclk_fall) begin
                            if (bit_count_output < FRAME_LEN)
                                rx_shift <= {rx_shift[30:0], mosi_q[1]};
                            bit_count_output <= (bit_count_output == 6'd63) ? bit_count_output : bit_count_output + 6'd1;
                        end
                    end
                end
                FINISH: begin
                    SPI_MISO <= 1'b0;
                    state    <= IDLE;
                    if (bit_count_output == FRAME_LEN) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: begin
                    SPI_MISO <= 1'b0;
                    if (cs_q[1])
                        state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_adc_responder.sv
`timescale 1ns/1ps
// tb_spi_adc_responder: drives SPI frames and checks against a word-level model of the responder
module tb_spi_adc_responder;
    localparam int H = 5;
    logic        clk = 0;
    logic        rst = 1;
    logic        sclk = 0;
    logic        cs = 1;
    logic        mosi = 0;
    logic        miso;
    logic [31:0] tx_data = 0;
    logic        tx_valid = 0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        frame_error;
    logic        tx_underrun;
    logic [5:0]  bit_count;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_rxv = 0;
    int n_ferr = 0;
    int n_und = 0;
    int strobe_cyc = 0;
    logic        m_full = 0;
    logic [31:0] m_hold = 0;
    logic [31:0] m_rx = 0;

    spi_adc_responder dut (
        .system_clock(clk), .reset(rst), .SPI_SCLK(sclk), .SPI_CS(cs), .SPI_MOSI(mosi),
        .SPI_MISO(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
        .tx_underrun(tx_underrun), .bit_count_output(bit_count)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (rx_valid) n_rxv++;
        if (frame_error) n_ferr++;
        if (tx_underrun) n_und++;
        if (rx_valid || frame_error) strobe_cyc = cyc;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] dflt();
`ifdef SPI_ADC_RESPONDER_CMD_ECHO_EN
        return {m_rx[31:16], 16'h0000};
`else
        return 32'h0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bit_xfer(input logic m, output logic s);
        sclk = 1; mosi = m;
        tick(H);
        s = miso;
        sclk = 0;
        tick(H);
    endtask

    task automatic push(input logic [31:0] w);
        tx_data = w; tx_valid = 1;
        tick(1);
        tx_valid = 0;
        if (!m_full) begin m_full = 1; m_hold = w; end
    endtask

    task automatic run_frame(input string name, input int nbits, input logic [31:0] mw, input bit sc, input logic [31:0] scw);
        logic [31:0] exp_resp, got, mask;
        logic exp_und, s;
        int rv, fe, un, c0, nb;
        logic [5:0] bc;
        if (sc) begin exp_resp = scw; exp_und = 0; end
        else begin exp_resp = m_full ? m_hold : dflt(); exp_und = !m_full; end
        m_full = 0;
        rv = n_rxv; fe = n_ferr; un = n_und; got = 0;
        cs = 0;
        if (sc) begin
            tick(2);
            tx_data = scw; tx_valid = 1;
            tick(1);
            tx_valid = 0;
            tick(H - 3);
        end else tick(H);
        for (int i = 0; i < nbits; i++) begin
            bit_xfer((i < 32) ? mw[31 - i] : 1'($urandom), s);
            if (i < 32) got[31 - i] = s;
        end
        bc = bit_count;
        cs = 1;
        c0 = cyc;
        tick(8);
        nb = (nbits > 63) ? 63 : nbits;
        mask = (nbits >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> nbits);
        checks++; if ((got & mask) !== (exp_resp & mask)) begin errors++; $display("FAIL %s miso_word: got %h expected %h", name, got & mask, exp_resp & mask); end
        checks++; if ((n_und - un) !== int'(exp_und)) begin errors++; $display("FAIL %s underrun_pulses: got %0d expected %0d", name, n_und - un, exp_und); end
        checks++; if (bc !== 6'(nb)) begin errors++; $display("FAIL %s bit_count: got %0d expected %0d", name, bc, nb); end
        checks++; if (strobe_cyc !== c0 + 4) begin errors++; $display("FAIL %s strobe_timing: got cycle %0d expected %0d", name, strobe_cyc, c0 + 4); end
        if (nbits == 32) m_rx = mw;
        checks++; if ((n_rxv - rv) !== ((nbits == 32) ? 1 : 0)) begin errors++; $display("FAIL %s rx_valid_pulses: got %0d expected %0d", name, n_rxv - rv, (nbits == 32) ? 1 : 0); end
        checks++; if ((n_ferr - fe) !== ((nbits == 32) ? 0 : 1)) begin errors++; $display("FAIL %s frame_error_pulses: got %0d expected %0d", name, n_ferr - fe, (nbits == 32) ? 0 : 1); end
        checks++; if (rx_data !== m_rx) begin errors++; $display("FAIL %s rx_data: got %h expected %h", name, rx_data, m_rx); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL %s miso_idle: got %b expected 0", name, miso); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL %s tx_ready_after: got %b expected 1", name, tx_ready); end
    endtask

    task automatic test_reset();
        tick(4);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset miso: got %b expected 0", miso); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset tx_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL reset rx_data: got %h expected 0", rx_data); end
        checks++; if ({rx_valid, frame_error, tx_underrun} !== 3'b000) begin errors++; $display("FAIL reset strobes: got %b expected 000", {rx_valid, frame_error, tx_underrun}); end
        checks++; if (bit_count !== 6'd0) begin errors++; $display("FAIL reset bit_count: got %0d expected 0", bit_count); end
        rst = 0;
        tick(4);
    endtask

    task automatic test_preload();
        push(32'hA5A5_1234);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL preload tx_ready_full: got %b expected 0", tx_ready); end
        push(32'h1111_1111);
        tick(3);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL preload tx_ready_held: got %b expected 0", tx_ready); end
        run_frame("preload", 32, 32'h0655_0000, 0, 0);
    endtask

    task automatic test_underrun();
        run_frame("underrun1", 32, 32'h0655_0000, 0, 0);
        run_frame("underrun2", 32, 32'h0655_0000, 0, 0);
    endtask

    task automatic test_short_frame();
        push($urandom);
        run_frame("short20", 20, $urandom, 0, 0);
    endtask

    task automatic test_long_frame();
        push($urandom);
        run_frame("long40", 40, $urandom, 0, 0);
    endtask

    task automatic test_reset_midframe();
        logic s, any_miso;
        int rv, fe, un;
        logic [31:0] w;
        w = $urandom;
        cs = 0;
        tick(H);
        for (int i = 0; i < 10; i++) bit_xfer(w[31 - i], s);
        rst = 1;
        tick(3);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midreset tx_ready: got %b expected 1", tx_ready); end
        rst = 0;
        m_full = 0; m_rx = 0;
        rv = n_rxv; fe = n_ferr; un = n_und; any_miso = 0;
        for (int i = 10; i < 32; i++) begin bit_xfer(w[31 - i], s); any_miso |= s; end
        checks++; if (any_miso !== 1'b0) begin errors++; $display("FAIL abort miso: got %b expected 0", any_miso); end
        checks++; if (bit_count !== 6'd0) begin errors++; $display("FAIL abort bit_count: got %0d expected 0", bit_count); end
        cs = 1;
        tick(10);
        checks++; if ((n_rxv - rv) + (n_ferr - fe) + (n_und - un) !== 0) begin errors++; $display("FAIL abort strobes: got %0d expected 0", (n_rxv - rv) + (n_ferr - fe) + (n_und - un)); end
        checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL abort rx_data: got %h expected 0", rx_data); end
        run_frame("post_abort", 32, $urandom, 0, 0);
    endtask

    task automatic test_same_cycle();
        run_frame("same_cycle", 32, $urandom, 1, 32'hDEAD_BEEF);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1) push($urandom);
            if ($urandom_range(0, 1) == 1) push($urandom);
            run_frame($sformatf("b2b%0d", k), 32, $urandom, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_underrun();
        test_short_frame();
        test_long_frame();
        test_reset_midframe();
        test_same_cycle();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
